hazard_scoreboard_ctrl: RTL

Parametrised successor to the load-use hazard detector. Each destination register has a countdown entry, so the pipeline supports ALU, load and multi-cycle operations of any fixed latency, plus one variable-latency unit (divider) that completes by handshake. Sits between the ID stage and the PC/IF-ID/ID-EX pipeline registers, and drives stall, bubble and flush.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/hazard_scoreboard_ctrl_if.sv | 41 ++++
 rtl/hazard_scoreboard_ctrl_sb_entry.sv | 40 ++++
 rtl/hazard_scoreboard_ctrl.sv | 94 +++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared widths and latency codes for the hazard scoreboard.
// Optional perf counters elsewhere are enabled by HZ_PERF_CNT_EN.
package hazard_pkg;
  localparam int REG_AW = 5;
  localparam int LAT_W  = 3;

  typedef logic [LAT_W-1:0] lat_t;

  localparam lat_t LAT_ALU  = lat_t'(0);
  localparam lat_t LAT_LOAD = lat_t'(1);
  localparam lat_t LAT_MUL  = lat_t'(2);
  localparam lat_t LAT_VAR  = '1;
endpackage

// File: rtl/hazard_scoreboard_ctrl_if.sv
// ID-stage / pipeline-control bundle of the hazard scoreboard.
// master = pipeline side, slave = scoreboard.
interface hazard_scoreboard_ctrl_if #(
  parameter int REG_AW = hazard_pkg::REG_AW,
  parameter int LAT_W  = hazard_pkg::LAT_W
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_rd_we;
  logic [LAT_W-1:0]  id_lat;
  logic              redirect;
  logic              lu_done;
  logic [REG_AW-1:0] lu_rd;
  logic              pc_write_en;
  logic              if_id_write_en;
  logic              id_ex_nop;
  logic              if_id_flush;
  logic              lu_busy;

  modport master (
    output id_valid, id_rs1, id_rs2,
    output id_rs1_used, id_rs2_used,
    output id_rd, id_rd_we, id_lat,
    output redirect, lu_done, lu_rd,
    input  pc_write_en, if_id_write_en,
    input  id_ex_nop, if_id_flush, lu_busy
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2,
    input  id_rs1_used, id_rs2_used,
    input  id_rd, id_rd_we, id_lat,
    input  redirect, lu_done, lu_rd,
    output pc_write_en, if_id_write_en,
    output id_ex_nop, if_id_flush, lu_busy
  );
endinterface

// File: rtl/hazard_scoreboard_ctrl_sb_entry.sv
// One scoreboard countdown entry; all-ones marks a variable-latency
// result that only clears on the completion handshake.
module sb_entry
  import hazard_pkg::*;
#(
  parameter int LAT_W = hazard_pkg::LAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_i,
  input  logic [LAT_W-1:0] set_val_i,
  input  logic             done_i,
  output logic [LAT_W-1:0] cnt_o
);
  localparam logic [LAT_W-1:0] VAR = '1;

  logic [LAT_W-1:0] cnt_q;
  logic [LAT_W-1:0] cnt_d;

  // a new issue overrides any completion in the same cycle
  always_comb begin
    cnt_d = cnt_q;
    if (set_i)
      cnt_d = set_val_i;
    else if (cnt_q == VAR) begin
      if (done_i)
        cnt_d = '0;
    end else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// Per-register latency scoreboard driving stall, bubble and flush.
// Define HZ_PERF_CNT_EN for stall/flush cycle counters.
module hazard_scoreboard_ctrl
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = hazard_pkg::REG_AW,
  parameter int LAT_W    = hazard_pkg::LAT_W
) (
  input  logic clk,
  input  logic rst,
  hazard_scoreboard_ctrl_if.slave hz
`ifdef HZ_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_cycles
`endif
);
  localparam logic [LAT_W-1:0] VAR = '1;

  logic [LAT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] var_hit;
  logic raw, waw, strc, stall, issue;

  assign cnt[0]     = '0;
  assign var_hit[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
    logic set, done;
    assign set = issue && hz.id_rd_we
              && (hz.id_rd == REG_AW'(r));
    assign done = hz.lu_done
               && (hz.lu_rd == REG_AW'(r));
    sb_entry #(.LAT_W(LAT_W)) u_ent (
      .clk       (clk),
      .rst       (rst),
      .set_i     (set),
      .set_val_i (hz.id_lat),
      .done_i    (done),
      .cnt_o     (cnt[r])
    );
    assign var_hit[r] = (cnt[r] == VAR);
  end

  assign hz.lu_busy = |var_hit;

  // entry 0 reads zero, so x0 never creates a hazard
  assign raw = hz.id_valid
    && ((hz.id_rs1_used && cnt[hz.id_rs1] != '0)
     || (hz.id_rs2_used && cnt[hz.id_rs2] != '0));
  assign waw = hz.id_valid && hz.id_rd_we
    && cnt[hz.id_rd] != '0;
  assign strc = hz.id_valid && hz.id_rd_we
    && hz.id_lat == VAR && hz.lu_busy;

  assign stall = (raw || waw || strc) && !hz.redirect;
  assign issue = hz.id_valid && !stall && !hz.redirect;

  always_comb begin
    hz.pc_write_en    = 1'b1;
    hz.if_id_write_en = 1'b1;
    hz.id_ex_nop      = 1'b0;
    hz.if_id_flush    = 1'b0;
    unique case (1'b1)
      hz.redirect: begin
        hz.if_id_flush = 1'b1;
        hz.id_ex_nop   = 1'b1;
      end
      stall: begin
        hz.pc_write_en    = 1'b0;
        hz.if_id_write_en = 1'b0;
        hz.id_ex_nop      = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef HZ_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_q + {31'd0, stall};
      flush_q <= flush_q + {31'd0, hz.redirect};
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_flush_cycles = flush_q;
`endif
endmodule
